fir_out_fifo: RTL and testbench
===============================

FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 Parameter OUT_W, default 16, width of each filtered output sample (matches `OUT_W).
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, SHALL be >= PIPE_LAT+2.
REQ-003 Parameter PIPE_LAT, default 3, FIR pipeline latency in cycles from input accept to output valid.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 i_data  input  OUT_W signed  filtered sample from the FIR output.
REQ-007 i_valid  input  1  i_data is valid this cycle; the FIR cannot stall, so no handshake on this side.
REQ-008 o_ready  output  1  credit signal to the FIR i_ready, which gates the source upstream of the FIR.
REQ-009 o_data  output  OUT_W signed  head-of-queue sample to the sink.
REQ-010 o_valid  output  1  o_data holds a valid sample.
REQ-011 i_ready  input  1  sink accepts o_data this cycle.
REQ-012 o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 o_overflow  output  1  sticky flag: a valid sample was dropped.
REQ-014 i_clr_ovf  input  1  clears o_overflow.

Function
REQ-015 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 Push SHALL occur when i_valid=1 and (count<DEPTH, or count=DEPTH with a pop in the same cycle).
REQ-017 Pop SHALL occur when o_valid=1 and i_ready=1.
REQ-018 Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, including at count=DEPTH.
REQ-019 Push to an empty buffer SHALL not bypass to the output; data SHALL appear on o_data with o_valid=1 on the cycle after the push edge (1-cycle latency).
REQ-020 First-word fall-through: o_data SHALL equal the entry at the read pointer whenever o_valid=1; o_valid SHALL be (count!=0).
REQ-021 o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022 o_ready SHALL be combinational from the registered count: o_ready = (count <= DEPTH-PIPE_LAT-1). With the defaults, o_ready=1 iff count<=4.
REQ-023 When o_ready is honoured upstream, this credit rule guarantees that no sample is dropped, because it covers the PIPE_LAT samples in flight in the FIR.
REQ-024 i_valid=1 at count=DEPTH with no pop: the sample SHALL be dropped, the buffer contents SHALL be unchanged, and o_overflow SHALL be set on the next edge.
REQ-025 o_overflow SHALL remain 1 until i_clr_ovf=1; if i_clr_ovf and a new drop occur in the same cycle, set SHALL win.
REQ-026 Sample values SHALL pass through bit-exact; no arithmetic is performed on the data.
REQ-027 i_valid=0 SHALL never modify storage or pointers, regardless of i_data.

Reset
REQ-028 rst=1 at a clock edge SHALL clear both pointers, count and o_overflow to 0, giving o_valid=0, o_count=0 and o_ready=1 from the next cycle.
REQ-029 Reset SHALL take priority over a push, pop or i_clr_ovf in the same cycle; stored data is discarded and memory contents need not be cleared.
REQ-030 Reset mid-operation (buffer partially full) SHALL produce the same state as reset from idle.

Verification
REQ-031 Single sample: push 0x1234 at cycle 0 with i_ready=0 -> at cycle 1, o_valid=1, o_data=0x1234, o_count=1; o_data stays 0x1234 until i_ready=1, then the pop empties the buffer.
REQ-032 Credit threshold: push 5 samples with i_ready=0 -> o_ready=1 at counts 0..4 and drops to 0 when count=5; pop one -> o_ready returns to 1.
REQ-033 Fill and overflow: push 8 samples 1..8 with i_ready=0, then push 9 -> o_count=8, o_overflow=1, and draining yields exactly 1..8 in order.
REQ-034 Full, simultaneous: at count=8, i_valid=1 with i_ready=1 -> count stays 8, o_overflow stays 0, and value 9 is delivered after 8.
REQ-035 Wrap-around: stream 20 consecutive samples with i_ready=1 every cycle -> output equals input delayed by 1 cycle, count stays <=1, and both pointers wrap.
REQ-036 Reset mid-stream: at count=5 with o_overflow=1, assert rst for one cycle together with i_valid=1 -> next cycle o_count=0, o_valid=0, o_overflow=0, o_ready=1.

Source files
------------

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: credit-managed output buffer behind a non-stallable FIR.
// The FIR cannot be stalled, so samples already in its pipeline still arrive
// after the upstream source is held off. o_ready deasserts early enough that
// those PIPE_LAT in-flight samples always find a free slot. Any sample that
// still arrives at a full buffer with no pop is dropped and flagged in a
// sticky overflow bit.
//
// Storage is a circular buffer with a registered-read memory. A head register
// is reloaded every cycle from the entry the read pointer will point to next.
// When that entry is being written in the same cycle, the incoming sample is
// taken directly. This gives first-word fall-through with one cycle of
// latency from push to o_valid.
//
// DEPTH must be a power of two and at least PIPE_LAT+2.
module fir_out_fifo #(
    parameter int OUT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [OUT_W-1:0]    i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic signed [OUT_W-1:0]    o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    // Highest occupancy at which upstream may still launch a sample: the
    // remaining slots must absorb everything already inside the FIR pipeline.
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH - PIPE_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);

    logic signed [OUT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic signed [OUT_W-1:0] head_q;

    logic push;
    logic pop;
    logic drop;
    logic head_bypass;

    // Handshake decode. A full buffer still accepts a sample when the sink
    // frees a slot in the same cycle, so push depends on pop.
    always_comb begin
        pop         = (count_q != '0) && i_ready;
        push        = i_valid && ((count_q < FULL_CNT) || pop);
        drop        = i_valid && !push;
        // The head to be loaded is the slot being written when the buffer
        // holds exactly this new sample after the edge.
        head_bypass = push && (wr_ptr_q == rd_ptr_d);
    end

    // Next-state computation for pointers, occupancy and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new drop wins over a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    // Registered read of the next head entry, with write-through bypass.
    always_ff @(posedge clk) begin
        if (head_bypass) begin
            head_q <= i_data;
        end else begin
            head_q <= mem[rd_ptr_d];
        end
    end

    // Output drive: everything comes from registered state.
    always_comb begin
        o_valid    = (count_q != '0);
        o_data     = head_q;
        o_count    = count_q;
        o_overflow = ovf_q;
        o_ready    = (count_q <= CREDIT_MAX);
    end

endmodule

// File: tb/tb_fir_out_fifo.sv
// Testbench for fir_out_fifo: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the buffer.
module tb_fir_out_fifo;

    localparam int OUT_W    = 16;
    localparam int DEPTH    = 8;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [OUT_W-1:0] i_data;
    logic                    i_valid;
    logic                    o_ready;
    logic signed [OUT_W-1:0] o_data;
    logic                    o_valid;
    logic                    i_ready;
    logic [CNT_W-1:0]        o_count;
    logic                    o_overflow;
    logic                    i_clr_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: contents in arrival order plus the sticky flag.
    logic signed [OUT_W-1:0] mq[$];
    logic                    m_ovf;

    fir_out_fifo #(.OUT_W(OUT_W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_overflow(o_overflow),
        .i_clr_ovf (i_clr_ovf)
    );

    always #5 clk = ~clk;

    // One clock: update the model from the inputs as seen at the edge, then
    // land 1 time unit after the edge where outputs are sampled.
    task automatic cycle();
        bit pop, push;
        pop  = (mq.size() != 0) && i_ready;
        push = i_valid && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(i_data);
            if (i_valid && !push) m_ovf = 1'b1;
            else if (i_clr_ovf) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; i_valid = 0; i_ready = 0; i_clr_ovf = 0; i_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic push_val(input logic signed [OUT_W-1:0] v);
        i_valid = 1; i_data = v; i_ready = 0;
        cycle();
        i_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_valid); end
        checks++; if (o_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        push_val(16'sh1234);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", o_valid); end
        checks++; if (o_count !== 1) begin errors++; $display("FAIL single_count got %0d want 1", o_count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_data !== 16'sh1234) begin errors++; $display("FAIL single_hold[%0d] got %h want 1234", k, o_data); end
            cycle();
        end
        i_ready = 1;
        cycle();
        i_ready = 0;
        checks++; if (o_valid !== 1'b0 || o_count !== 0) begin errors++; $display("FAIL single_pop got valid=%0b count=%0d want 0/0", o_valid, o_count); end
        $display("test_single done");
    endtask

    task automatic test_credit();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL credit_ready_at_%0d got %0b want 1", k, o_ready); end
            push_val(OUT_W'(k + 100));
        end
        checks++; if (o_ready !== 1'b0 || o_count !== 5) begin errors++; $display("FAIL credit_at_5 got ready=%0b count=%0d want 0/5", o_ready, o_count); end
        i_ready = 1;
        cycle();
        i_ready = 0;
        checks++; if (o_ready !== 1'b1 || o_count !== 4) begin errors++; $display("FAIL credit_after_pop got ready=%0b count=%0d want 1/4", o_ready, o_count); end
        $display("test_credit done");
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int k = 1; k <= 8; k++) push_val(OUT_W'(k));
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %0b want 0", o_overflow); end
        push_val(OUT_W'(9));
        checks++; if (o_count !== 8 || o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got count=%0d ovf=%0b want 8/1", o_count, o_overflow); end
        i_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== OUT_W'(k)) begin errors++; $display("FAIL fill_drain[%0d] got valid=%0b data=%0d want 1/%0d", k, o_valid, o_data, k); end
            cycle();
        end
        i_ready = 0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %0b want 0", o_valid); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", o_overflow); end
        i_clr_ovf = 1;
        cycle();
        i_clr_ovf = 0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", o_overflow); end
        $display("test_fill_overflow done");
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int k = 1; k <= 8; k++) push_val(OUT_W'(k));
        i_valid = 1; i_data = 9; i_ready = 1;
        cycle();
        i_valid = 0;
        checks++; if (o_count !== 8 || o_overflow !== 1'b0) begin errors++; $display("FAIL simul_full got count=%0d ovf=%0b want 8/0", o_count, o_overflow); end
        for (int k = 2; k <= 9; k++) begin
            checks++; if (o_data !== OUT_W'(k)) begin errors++; $display("FAIL simul_drain[%0d] got %0d want %0d", k, o_data, k); end
            cycle();
        end
        i_ready = 0;
        $display("test_full_simul done");
    endtask

    task automatic test_set_wins();
        do_reset();
        for (int k = 1; k <= 8; k++) push_val(OUT_W'(k));
        i_valid = 1; i_clr_ovf = 1; i_data = 77;
        cycle();
        i_valid = 0; i_clr_ovf = 0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL set_wins got %0b want 1", o_overflow); end
        $display("test_set_wins done");
    endtask

    task automatic test_wrap();
        logic signed [OUT_W-1:0] v;
        do_reset();
        i_ready = 1; i_valid = 1;
        for (int k = 0; k < 20; k++) begin
            v = OUT_W'($urandom);
            i_data = v;
            cycle();
            checks++; if (o_valid !== 1'b1 || o_data !== v || o_count > 1) begin errors++; $display("FAIL wrap[%0d] got valid=%0b data=%h count=%0d want 1/%h/<=1", k, o_valid, o_data, o_count, v); end
        end
        i_valid = 0;
        cycle();
        i_ready = 0;
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 9; k++) push_val(OUT_W'(k));
        i_ready = 1;
        repeat (3) cycle();
        i_ready = 0;
        checks++; if (o_count !== 5 || o_overflow !== 1'b1) begin errors++; $display("FAIL mid_setup got count=%0d ovf=%0b want 5/1", o_count, o_overflow); end
        rst = 1; i_valid = 1; i_data = 55;
        cycle();
        rst = 0; i_valid = 0;
        checks++; if (o_count !== 0 || o_valid !== 0 || o_overflow !== 0 || o_ready !== 1) begin errors++; $display("FAIL mid_reset got count=%0d valid=%0b ovf=%0b ready=%0b want 0/0/0/1", o_count, o_valid, o_overflow, o_ready); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 2) == 0);
            i_clr_ovf = ($urandom_range(0, 15) == 0);
            i_data    = OUT_W'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
            exp_cnt = CNT_W'(mq.size());
            checks++;
            if (o_count !== exp_cnt || o_valid !== (mq.size() != 0) || o_overflow !== m_ovf ||
                o_ready !== (mq.size() <= DEPTH - PIPE_LAT - 1) ||
                (mq.size() != 0 && o_data !== mq[0])) begin
                errors++;
                $display("FAIL random[%0d] got count=%0d valid=%0b ovf=%0b ready=%0b data=%h want count=%0d ovf=%0b head=%h",
                         k, o_count, o_valid, o_overflow, o_ready, o_data, exp_cnt, m_ovf,
                         (mq.size() != 0) ? mq[0] : '0);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        m_ovf = 1'b0;
        idle_inputs();
        rst = 1;
        repeat (2) cycle();
        test_reset();
        test_single();
        test_credit();
        test_fill_overflow();
        test_full_simul();
        test_set_wins();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
